tx_sched: RTL and testbench

Transmit scheduler for the tx0 port: turns the host-programmed tx0 registers (enable, frame length, inter-frame gap, ARP request) into one-cycle start commands for the packet generator. It paces frames with a gap counter and gives ARP requests priority over data frames. It also produces the once-per-second tx0 packet-rate and throughput statistics read back over PCIe. It sits between the PCIe user register file and the tx0 frame generator, in the same clock domain as both.

---
 rtl/tx_sched.sv | 170 +++++++++++++++++
 tb/tb_tx_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched.sv
// tx0 transmit scheduler: paces data/ARP frame starts with an inter-frame gap and keeps per-window rate statistics.
// Build option: define TX_SCHED_JUMBO_EN to raise the clamp ceiling from 1518 to 9018 bytes.
module tx_sched #(
  parameter int unsigned CLK_HZ  = 156250000,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable_i,
  input  logic [15:0] frame_len_i,
  input  logic [31:0] inter_frame_gap_i,
  input  logic        req_arp_i,
  output logic        arp_ack_o,
  input  logic        gen_ready_i,
  output logic        gen_start_o,
  output logic        gen_kind_o,
  output logic [15:0] gen_len_o,
  input  logic        gen_done_i,
  output logic        busy_o,
  output logic [31:0] pps_o,
  output logic [31:0] throughput_o
);

`ifdef TX_SCHED_JUMBO_EN
  localparam logic [15:0] MAX_LEN = 16'd9018;
`else
  localparam logic [15:0] MAX_LEN = 16'd1518;
`endif
  localparam logic [15:0]      MIN_LEN_W = 16'(MIN_LEN);
  localparam int unsigned      WIN_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(CLK_HZ - 1);

  // state | meaning
  // IDLE  | no frame in flight, start on the next eligible request
  // FRAME | generator transmitting, waiting for gen_done
  // GAP   | inter-frame gap countdown; last GAP cycle may launch the next start
  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] gap_q, gap_d;
  logic        start_q, start_d;
  logic        ack_q, ack_d;
  logic        kind_q, kind_d;
  logic [15:0] len_q, len_d;
  logic [15:0] clamp_len;
  logic        decide;

  logic [WIN_W-1:0] win_q, win_d;
  logic [31:0]      frames_q, frames_d, bytes_q, bytes_d;
  logic [31:0]      pps_q, pps_d, thr_q, thr_d;
  logic [31:0]      frames_inc, bytes_inc;
  logic [32:0]      bytes_sum;
  logic             wrap, count_done;

  always_comb begin
    clamp_len = frame_len_i;
    if (frame_len_i < MIN_LEN_W) begin
      clamp_len = MIN_LEN_W;
    end else if (frame_len_i > MAX_LEN) begin
      clamp_len = MAX_LEN;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    kind_d  = kind_q;
    len_d   = len_q;
    decide  = 1'b0;
    case (state_q)
      ST_IDLE: decide = 1'b1;
      ST_FRAME: begin
        if (gen_done_i) begin
          if (inter_frame_gap_i == 32'd0) begin
            decide  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = inter_frame_gap_i;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 32'd1;
        if (gap_q == 32'd1) begin
          decide  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Blocking on start_q keeps a zero-gap frame that finishes instantly from giving back-to-back starts.
    if (decide && gen_ready_i && !start_q) begin
      if (req_arp_i) begin
        state_d = ST_FRAME;
        start_d = 1'b1;
        ack_d   = 1'b1;
        kind_d  = 1'b1;
        len_d   = MIN_LEN_W;
      end else if (tx_enable_i) begin
        state_d = ST_FRAME;
        start_d = 1'b1;
        kind_d  = 1'b0;
        len_d   = clamp_len;
      end
    end
  end

  always_comb begin
    wrap       = (win_q == WIN_LAST);
    win_d      = wrap ? '0 : win_q + WIN_W'(1);
    count_done = gen_done_i && (state_q == ST_FRAME) && !kind_q;
    bytes_sum  = {1'b0, bytes_q} + {17'd0, len_q};
    frames_inc = frames_q;
    bytes_inc  = bytes_q;
    if (count_done) begin
      frames_inc = (&frames_q) ? frames_q : frames_q + 32'd1;
      bytes_inc  = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
    end
    pps_d    = pps_q;
    thr_d    = thr_q;
    frames_d = frames_inc;
    bytes_d  = bytes_inc;
    if (wrap) begin
      pps_d    = frames_inc;
      thr_d    = bytes_inc;
      frames_d = 32'd0;
      bytes_d  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= 32'd0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      kind_q   <= 1'b0;
      len_q    <= MIN_LEN_W;
      win_q    <= '0;
      frames_q <= 32'd0;
      bytes_q  <= 32'd0;
      pps_q    <= 32'd0;
      thr_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      kind_q   <= kind_d;
      len_q    <= len_d;
      win_q    <= win_d;
      frames_q <= frames_d;
      bytes_q  <= bytes_d;
      pps_q    <= pps_d;
      thr_q    <= thr_d;
    end
  end

  assign gen_start_o  = start_q;
  assign arp_ack_o    = ack_q;
  assign gen_kind_o   = kind_q;
  assign gen_len_o    = len_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign pps_o        = pps_q;
  assign throughput_o = thr_q;

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: pacing, ARP priority, clamp, enable drop, statistics window and mid-frame reset.
module tb_tx_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic [15:0] frame_len = 16'd64;
  logic [31:0] gap = 32'd10;
  logic        req_arp = 1'b0;
  logic        arp_ack;
  logic        gen_ready = 1'b0;
  logic        gen_start;
  logic        gen_kind;
  logic [15:0] gen_len;
  logic        gen_done = 1'b0;
  logic        busy;
  logic [31:0] pps;
  logic [31:0] thr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

`ifdef TX_SCHED_JUMBO_EN
  localparam int MAXL = 9018;
`else
  localparam int MAXL = 1518;
`endif

  tx_sched #(.CLK_HZ(1000), .MIN_LEN(60)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_enable_i(tx_enable), .frame_len_i(frame_len), .inter_frame_gap_i(gap),
    .req_arp_i(req_arp), .arp_ack_o(arp_ack), .gen_ready_i(gen_ready),
    .gen_start_o(gen_start), .gen_kind_o(gen_kind), .gen_len_o(gen_len),
    .gen_done_i(gen_done), .busy_o(busy), .pps_o(pps), .throughput_o(thr)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // From the current cycle, tick k times, then hold gen_done for one cycle.
  task automatic frame_done(input int k);
    repeat (k) tick();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
  endtask

  task automatic wait_start(input int max, output int n);
    n = 0;
    while (!gen_start && n < max) begin
      tick();
      n++;
    end
    chk_eq("start_seen", 32'(gen_start), 32'd1);
  endtask

  int n;
  int starts;
  int lens[8]  = '{20, 59, 60, 1518, 1519, 4000, 9018, 9500};
  int exps[8];

  initial begin
    exps = '{60, 60, 60, 1518, (MAXL > 1519) ? 1519 : MAXL,
             (MAXL > 4000) ? 4000 : MAXL, MAXL, MAXL};
    do_reset();
    chk_eq("rst_start", 32'(gen_start), 32'd0);
    chk_eq("rst_ack",   32'(arp_ack),   32'd0);
    chk_eq("rst_kind",  32'(gen_kind),  32'd0);
    chk_eq("rst_len",   32'(gen_len),   32'd60);
    chk_eq("rst_busy",  32'(busy),      32'd0);
    chk_eq("rst_pps",   pps,            32'd0);
    chk_eq("rst_thr",   thr,            32'd0);

    // Steady pacing: 8-cycle frames with G=10 give a 19-cycle start period.
    tx_enable = 1'b1; frame_len = 16'd64; gap = 32'd10; gen_ready = 1'b1;
    wait_start(5, n);
    chk_eq("first_lat", 32'(n), 32'd1);
    chk_eq("first_kind", 32'(gen_kind), 32'd0);
    chk_eq("first_len", 32'(gen_len), 32'd64);
    for (int i = 0; i < 3; i++) begin
      frame_done(8);
      wait_start(40, n);
      chk_eq("period", 32'(n + 9), 32'd19);
      chk_eq("per_kind", 32'(gen_kind), 32'd0);
      chk_eq("per_len", 32'(gen_len), 32'd64);
    end

    // Clamp; frame_len changed mid-frame must not disturb the latched length.
    for (int i = 0; i < 8; i++) begin
      n = int'(gen_len);
      frame_len = 16'(lens[i]);
      tick();
      chk_eq("len_held", 32'(gen_len), 32'(n));
      chk_eq("no_dbl", 32'(gen_start), 32'd0);
      frame_done(7);
      wait_start(40, n);
      chk_eq("clamp_gap", 32'(n), 32'd10);
      chk_eq("clamp_len", 32'(gen_len), 32'(exps[i]));
    end

    // G=0: next start in the cycle right after gen_done.
    frame_len = 16'd64;
    gap = 32'd0;
    frame_done(8);
    wait_start(40, n);
    chk_eq("gap0", 32'(n), 32'd0);
    gap = 32'd10;

    // Enable dropped after start: frame and gap finish, then idle.
    tick();
    tx_enable = 1'b0;
    frame_done(7);
    for (int i = 0; i < 10; i++) begin
      chk_eq("drop_busy", 32'(busy), 32'd1);
      tick();
    end
    chk_eq("drop_idle", 32'(busy), 32'd0);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gen_start) starts++;
    end
    chk_eq("drop_nostart", 32'(starts), 32'd0);
    tx_enable = 1'b1;
    tick();
    chk_eq("reassert", 32'(gen_start), 32'd1);

    // ARP priority over data, then data follows after G+1.
    frame_done(8);
    tx_enable = 1'b0;
    repeat (12) tick();
    chk_eq("pre_arp_idle", 32'(busy), 32'd0);
    req_arp = 1'b1; tx_enable = 1'b1;
    tick();
    chk_eq("arp_start", 32'(gen_start), 32'd1);
    chk_eq("arp_ack",   32'(arp_ack),   32'd1);
    chk_eq("arp_kind",  32'(gen_kind),  32'd1);
    chk_eq("arp_len",   32'(gen_len),   32'd60);
    req_arp = 1'b0;
    tick();
    chk_eq("arp_ack_pulse", 32'(arp_ack), 32'd0);
    frame_done(7);
    wait_start(40, n);
    chk_eq("arp_next_gap", 32'(n), 32'd10);
    chk_eq("arp_next_kind", 32'(gen_kind), 32'd0);
    chk_eq("arp_next_len", 32'(gen_len), 32'd64);

    // Statistics: window of 1000 cycles, 5th data done lands on the wrap cycle.
    tx_enable = 1'b0;
    do_reset();
    frame_len = 16'd100; gap = 32'd3; gen_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      n = (f < 4) ? 20 + 50 * f : 990;
      tick_to(n - 1);
      tx_enable = 1'b1;
      tick();
      chk_eq("st_start", 32'(gen_start), 32'd1);
      tx_enable = 1'b0;
      tick_to((f < 4) ? n + 5 : 999);
      gen_done = 1'b1;
      if (f == 4) begin
        chk_eq("st_pps_pre", pps, 32'd0);
        chk_eq("st_thr_pre", thr, 32'd0);
      end
      tick();
      gen_done = 1'b0;
    end
    chk_eq("st_pps_w1", pps, 32'd5);
    chk_eq("st_thr_w1", thr, 32'd500);
    // Second window: one ARP (not counted) and one 200-byte data frame.
    tick_to(1019);
    req_arp = 1'b1;
    tick();
    chk_eq("st_arp_ack", 32'(arp_ack), 32'd1);
    req_arp = 1'b0;
    tick_to(1025);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    frame_len = 16'd200;
    tick_to(1049);
    tx_enable = 1'b1;
    tick();
    tx_enable = 1'b0;
    tick_to(1055);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    tick_to(1500);
    chk_eq("st_pps_hold", pps, 32'd5);
    chk_eq("st_thr_hold", thr, 32'd500);
    tick_to(1999);
    chk_eq("st_pps_hold2", pps, 32'd5);
    tick();
    chk_eq("st_pps_w2", pps, 32'd1);
    chk_eq("st_thr_w2", thr, 32'd200);

    // Reset while in FRAME.
    frame_len = 16'd300;
    tick_to(2009);
    tx_enable = 1'b1;
    tick();
    chk_eq("mr_start", 32'(gen_start), 32'd1);
    chk_eq("mr_len", 32'(gen_len), 32'd300);
    tx_enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_eq("mr_start0", 32'(gen_start), 32'd0);
    chk_eq("mr_ack0",   32'(arp_ack),   32'd0);
    chk_eq("mr_kind0",  32'(gen_kind),  32'd0);
    chk_eq("mr_len0",   32'(gen_len),   32'd60);
    chk_eq("mr_busy0",  32'(busy),      32'd0);
    chk_eq("mr_pps0",   pps,            32'd0);
    chk_eq("mr_thr0",   thr,            32'd0);
    rst_n = 1'b1;
    tick();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk_eq("mr_done_ign_busy", 32'(busy), 32'd0);
    chk_eq("mr_done_ign_start", 32'(gen_start), 32'd0);
    tick();
    chk_eq("mr_idle", 32'(busy), 32'd0);
    tx_enable = 1'b1;
    tick();
    chk_eq("mr_restart", 32'(gen_start), 32'd1);
    chk_eq("mr_restart_len", 32'(gen_len), 32'd300);
    chk_eq("mr_restart_kind", 32'(gen_kind), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
